button_event: RTL and testbench
===============================

Name: button_event

Overview:
- Consumes a clean, already-debounced button level and converts it into one-cycle event strobes: press, release, short-press, long-press and auto-repeat.
- Sits directly downstream of the button debouncers, between them and the GPU/VGA control logic (mode select, cursor step, colour cycling).
- Control logic never edge-detects or times button levels itself.

Parameters:
- CNT_W, 24, width of the hold-time counter.
- LONG_TICKS, 24'd12_500_000, clocks of continuous hold before long_press (about 0.5 s at 25 MHz); legal range is 2 to 2^CNT_W-1.
- REPEAT_TICKS, 24'd2_500_000, clocks between repeat_pulse strobes while long-held; 0 disables auto-repeat.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- btn_level  in  1  debounced button level, 1 = pressed; synchronous to clk
- press_pulse  out  1  one-cycle strobe on press
- release_pulse  out  1  one-cycle strobe on any release
- short_press  out  1  one-cycle strobe on release before the long threshold
- long_press  out  1  one-cycle strobe when the hold reaches LONG_TICKS
- repeat_pulse  out  1  one-cycle strobe every REPEAT_TICKS while long-held
- held  out  1  level, 1 while state is PRESS or LONG

Behaviour:
- Reset:
  - state=IDLE, cnt=0, btn_q=0.
  - All outputs 0.
  - Reset mid-operation aborts with no release or short strobe.
- Edge detect: btn_q <= btn_level every cycle.
  - rise = btn_level & ~btn_q.
  - fall = ~btn_level & btn_q.
- Held through reset: btn_q resets to 0, so a button still held when reset deasserts produces a fresh press.
- Registered outputs: all strobes are registered and are high for exactly one cycle, on the cycle after the clock edge that makes the decision.
- Latency from btn_level sampled at edge k: press_pulse is high during the cycle after edge k.
- FSM states: IDLE, PRESS, LONG. cnt is CNT_W bits unsigned, cleared on every state entry.
- IDLE:
  - On rise: go to PRESS, set cnt=0, assert press_pulse.
- PRESS:
  - If fall: go to IDLE, assert release_pulse and short_press in the same cycle.
  - Else if cnt==LONG_TICKS-1: go to LONG, set cnt=0, assert long_press.
  - Else cnt++.
- LONG:
  - If fall: go to IDLE, assert release_pulse only.
  - Else if REPEAT_TICKS!=0 and cnt==REPEAT_TICKS-1: assert repeat_pulse, set cnt=0.
  - Else if REPEAT_TICKS!=0: cnt++.
  - If REPEAT_TICKS==0: cnt holds at 0.
- Simultaneous events: fall takes priority over the terminal count.
  - Release on the terminal cycle in PRESS gives short_press, not long_press.
  - Release on the terminal cycle in LONG gives no repeat_pulse.
- Mutual exclusion:
  - press_pulse and release_pulse never assert together.
  - long_press and short_press never occur in the same press.
- Minimum press: a 1-cycle-high btn_level gives press_pulse, then release_pulse+short_press on the next cycle.
- Counter bounds: cnt never exceeds max(LONG_TICKS, REPEAT_TICKS)-1, so no wrap-around is possible.
- held is a combinational decode of the registered state (no glitches).

Decomposition:
- Shared package (button_pkg):
  - state enum BTN_IDLE=2'd0, BTN_PRESS=2'd1, BTN_LONG=2'd2.
  - Default timing constants LONG_TICKS_DEFAULT and REPEAT_TICKS_DEFAULT, referenced by the top level.
- No sub-module: single flat block.
- The top level instantiates one button_event per debouncer output.

Test Plan:
All scenarios use LONG_TICKS=8, REPEAT_TICKS=4 unless stated; k = the edge where rise is sampled.
1. Short press: btn_level high for 5 cycles, then low -> press_pulse during cycle k+1; release_pulse and short_press for 1 cycle after the fall edge; long_press and repeat_pulse stay 0; held high for 5 cycles.
2. Long hold with repeat: btn_level high for 24 cycles -> press_pulse at k+1; long_press after edge k+8; repeat_pulse after edges k+12, k+16, k+20; on release, release_pulse only (short_press=0).
3. Terminal-cycle release: fall sampled at edge k+8 -> short_press=1, release_pulse=1, long_press never asserts; state returns to IDLE.
4. REPEAT_TICKS=0: hold for 30 cycles -> exactly one long_press and zero repeat_pulse.
5. Reset mid-hold: assert rst_n=0 at k+5 for 2 cycles with btn_level still 1 -> all outputs 0 during reset, no release_pulse; one new press_pulse on the cycle after the first post-reset edge.
6. One-cycle pulse then back-to-back press: btn_level 1,0,1 on consecutive cycles -> press, release+short, press strobes on three consecutive cycles; no two strobes from different events overlap.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the button event block: FSM state encoding and
// default hold/repeat timing at a 25 MHz system clock.
package button_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE  = 2'd0,
    BTN_PRESS = 2'd1,
    BTN_LONG  = 2'd2
  } btn_state_e;

  localparam int unsigned CNT_W_DEFAULT        = 24;
  localparam logic [23:0] LONG_TICKS_DEFAULT   = 24'd12_500_000;
  localparam logic [23:0] REPEAT_TICKS_DEFAULT = 24'd2_500_000;

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into registered one-cycle strobes:
// press, release, short press, long press and auto-repeat while long-held.
module button_event
  import button_pkg::*;
#(
  parameter int unsigned      CNT_W        = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] LONG_TICKS   = CNT_W'(LONG_TICKS_DEFAULT),
  parameter logic [CNT_W-1:0] REPEAT_TICKS = CNT_W'(REPEAT_TICKS_DEFAULT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_TICKS - CNT_W'(1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_TICKS - CNT_W'(1);
  localparam logic             REPEAT_EN   = (REPEAT_TICKS != '0);

  btn_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             btn_q;
  logic             rise, fall;
  logic             press_nxt, release_nxt, short_nxt, long_nxt, repeat_nxt;

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;
  assign held = (state != BTN_IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    unique case (state)
      BTN_IDLE: begin
        if (rise) begin
          state_nxt = BTN_PRESS;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end
      end
      BTN_PRESS: begin
        // A release on the terminal cycle still counts as a short press.
        if (fall) begin
          state_nxt   = BTN_IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
          short_nxt   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_nxt = BTN_LONG;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BTN_LONG: begin
        if (fall) begin
          state_nxt   = BTN_IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else if (REPEAT_EN) begin
          if (cnt == REPEAT_LAST) begin
            repeat_nxt = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = BTN_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Clearing btn_q in reset makes a button still held at reset exit look like a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= BTN_IDLE;
      cnt           <= '0;
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      btn_q         <= btn_level;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      short_press   <= short_nxt;
      long_press    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: one instance with auto-repeat (A), one
// with auto-repeat disabled (B), both driven by the same button and reset.
module tb_button_event;

  typedef struct packed {
    int         cyc;
    logic [5:0] vec;   // {held, press, release, short, long, repeat}
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_level;
  logic a_press, a_release, a_short, a_long, a_repeat, a_held;
  logic b_press, b_release, b_short, b_long, b_repeat, b_held;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic a_prev_held = 1'b0;
  logic b_prev_held = 1'b0;
  ev_t  qa[$];
  ev_t  qb[$];

  button_event #(.CNT_W(24), .LONG_TICKS(24'd8), .REPEAT_TICKS(24'd4)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
    .press_pulse(a_press), .release_pulse(a_release), .short_press(a_short),
    .long_press(a_long), .repeat_pulse(a_repeat), .held(a_held)
  );

  button_event #(.CNT_W(24), .LONG_TICKS(24'd8), .REPEAT_TICKS(24'd0)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
    .press_pulse(b_press), .release_pulse(b_release), .short_press(b_short),
    .long_press(b_long), .repeat_pulse(b_repeat), .held(b_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wire [5:0] vec_a = {a_held, a_press, a_release, a_short, a_long, a_repeat};
  wire [5:0] vec_b = {b_held, b_press, b_release, b_short, b_long, b_repeat};

  task automatic exp_a(input int c, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    qa.push_back(e);
  endtask

  task automatic exp_b(input int c, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    qb.push_back(e);
  endtask

  task automatic exp_ab(input int c, input logic [5:0] v);
    exp_a(c, v);
    exp_b(c, v);
  endtask

  task automatic check_ev(input bit is_b, input logic [5:0] v);
    ev_t e;
    checks++;
    if (is_b ? (qb.size() == 0) : (qa.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_event dut_%s cycle %0d: got %b, expected no event",
               is_b ? "b" : "a", cyc, v);
    end else begin
      e = is_b ? qb.pop_front() : qa.pop_front();
      if (e.cyc != cyc || e.vec != v) begin
        errors++;
        $display("FAIL event dut_%s: got cycle %0d vec %b, expected cycle %0d vec %b",
                 is_b ? "b" : "a", cyc, v, e.cyc, e.vec);
      end
    end
  endtask

  // Monitor: an event is any strobe or any change of held.
  always @(negedge clk) begin
    if (mon_en) begin
      if (vec_a[4:0] != 5'b0 || vec_a[5] != a_prev_held) check_ev(1'b0, vec_a);
      if (vec_b[4:0] != 5'b0 || vec_b[5] != b_prev_held) check_ev(1'b1, vec_b);
    end
    a_prev_held = a_held;
    b_prev_held = b_held;
  end

  task automatic hold_cycles(input int n);
    btn_level = 1'b1;
    repeat (n) @(negedge clk);
    btn_level = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    btn_level = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (vec_a != 6'b0 || vec_b != 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%b b=%b, expected 000000", vec_a, vec_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    gap(2);

    // Short press: 5 cycles high.
    k = cyc + 1;
    exp_ab(k,     6'b110000);
    exp_ab(k + 5, 6'b001100);
    hold_cycles(5);
    gap(4);

    // Long hold 24 cycles: repeats only on A; release without short.
    k = cyc + 1;
    exp_ab(k,     6'b110000);
    exp_ab(k + 8, 6'b100010);
    exp_a(k + 12, 6'b100001);
    exp_a(k + 16, 6'b100001);
    exp_a(k + 20, 6'b100001);
    exp_ab(k + 24, 6'b001000);
    hold_cycles(24);
    gap(4);

    // Fall sampled on the terminal-count edge: short, never long.
    k = cyc + 1;
    exp_ab(k,     6'b110000);
    exp_ab(k + 8, 6'b001100);
    hold_cycles(8);
    gap(4);

    // 30-cycle hold: one long press each; B never repeats.
    k = cyc + 1;
    exp_ab(k,     6'b110000);
    exp_ab(k + 8, 6'b100010);
    exp_a(k + 12, 6'b100001);
    exp_a(k + 16, 6'b100001);
    exp_a(k + 20, 6'b100001);
    exp_a(k + 24, 6'b100001);
    exp_a(k + 28, 6'b100001);
    exp_ab(k + 30, 6'b001000);
    hold_cycles(30);
    gap(4);

    // Reset mid-hold: no release, fresh press after reset.
    k = cyc + 1;
    exp_ab(k,      6'b110000);
    exp_ab(k + 5,  6'b000000);
    exp_ab(k + 7,  6'b110000);
    exp_ab(k + 11, 6'b001100);
    btn_level = 1'b1;
    gap(5);
    rst_n = 1'b0;
    gap(2);
    rst_n = 1'b1;
    gap(4);
    btn_level = 1'b0;
    gap(4);

    // 1,0,1 pattern: press, release+short, press on consecutive cycles.
    k = cyc + 1;
    exp_ab(k,     6'b110000);
    exp_ab(k + 1, 6'b001100);
    exp_ab(k + 2, 6'b110000);
    exp_ab(k + 5, 6'b001100);
    btn_level = 1'b1;
    gap(1);
    btn_level = 1'b0;
    gap(1);
    hold_cycles(3);
    gap(6);

    mon_en = 1'b0;
    while (qa.size() != 0) begin
      ev_t e;
      e = qa.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event dut_a: got nothing, expected cycle %0d vec %b", e.cyc, e.vec);
    end
    while (qb.size() != 0) begin
      ev_t e;
      e = qb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event dut_b: got nothing, expected cycle %0d vec %b", e.cyc, e.vec);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
